// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID/EX/MEM pipeline control and the hazard controller.
// master drives hazard inputs and receives enables/flushes; slave is the controller.
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic [4:0]        ID_rs;
  logic [4:0]        ID_rt;
  logic              ID_useRs;
  logic              ID_useRt;
  logic [1:0]        ID_Branch;
  logic [1:0]        ID_Jump;
  logic              ID_redirect;
  logic              EX_RegWrite;
  logic [1:0]        EX_RegSrc;
  logic [4:0]        EX_WriteReg;
  logic              MEM_RegWrite;
  logic [1:0]        MEM_RegSrc;
  logic [4:0]        MEM_WriteReg;
  logic              dmem_busy;
  logic              PC_Write;
  logic              IFID_Write;
  logic              IFID_Flush;
  logic              IDEX_Flush;
  logic              EXMEM_Write;
  logic              MEMWB_Write;
  logic              Stalling;
  logic [PERF_W-1:0] perf_stall_cycles;
  logic [PERF_W-1:0] perf_flushes;

  modport master (
    output ID_rs, ID_rt, ID_useRs, ID_useRt, ID_Branch, ID_Jump, ID_redirect,
           EX_RegWrite, EX_RegSrc, EX_WriteReg,
           MEM_RegWrite, MEM_RegSrc, MEM_WriteReg, dmem_busy,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Write,
           Stalling, perf_stall_cycles, perf_flushes
  );

  modport slave (
    input  ID_rs, ID_rt, ID_useRs, ID_useRt, ID_Branch, ID_Jump, ID_redirect,
           EX_RegWrite, EX_RegSrc, EX_WriteReg,
           MEM_RegWrite, MEM_RegSrc, MEM_WriteReg, dmem_busy,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Write,
           Stalling, perf_stall_cycles, perf_flushes
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: ID-bypass stalls, redirect flush, dmem freeze.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_EN.
`ifndef BRANCH_NONE
`define BRANCH_NONE 2'b00
`endif
`ifndef JUMP_REG
`define JUMP_REG 2'b10
`endif
`ifndef REGSRC_ALU
`define REGSRC_ALU 2'b00
`endif
`ifndef REGSRC_MEM
`define REGSRC_MEM 2'b01
`endif
`ifndef REGSRC_PCPLUS4
`define REGSRC_PCPLUS4 2'b10
`endif

module hazard_ctrl #(
  parameter int STALL_W = 2,
  parameter int PERF_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic               use_id_s;
  logic [1:0]         need_rs_s, need_rt_s, need_s;
  logic               pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s;
  logic               exmem_write_s, memwb_write_s, stalling_s;

  function automatic logic src_match(input logic [4:0] src, input logic used,
                                     input logic wr, input logic [4:0] wreg);
    return used && wr && (wreg != 5'd0) && (wreg == src);
  endfunction

  // WB is write-first in the RF, so only EX and MEM producers can be too late.
  function automatic logic [1:0] need_for(input logic ex_hit, input logic mem_hit,
                                          input logic use_id, input logic [1:0] ex_src,
                                          input logic [1:0] mem_src);
    logic [1:0] n;
    n = 2'd0;
    if (mem_hit && use_id && (mem_src == `REGSRC_MEM)) n = 2'd1;
    if (ex_hit) begin
      if (ex_src == `REGSRC_MEM)                  n = use_id ? 2'd2 : 2'd1;
      else if ((ex_src == `REGSRC_ALU) && use_id) n = 2'd1;
      else                                        n = n;
    end
    return n;
  endfunction

  // Stall requirement: worst case over both source operands.
  always_comb begin
    use_id_s  = (bus.ID_Branch != `BRANCH_NONE) || (bus.ID_Jump == `JUMP_REG);
    need_rs_s = need_for(src_match(bus.ID_rs, bus.ID_useRs, bus.EX_RegWrite, bus.EX_WriteReg),
                         src_match(bus.ID_rs, bus.ID_useRs, bus.MEM_RegWrite, bus.MEM_WriteReg),
                         use_id_s, bus.EX_RegSrc, bus.MEM_RegSrc);
    need_rt_s = need_for(src_match(bus.ID_rt, bus.ID_useRt, bus.EX_RegWrite, bus.EX_WriteReg),
                         src_match(bus.ID_rt, bus.ID_useRt, bus.MEM_RegWrite, bus.MEM_WriteReg),
                         use_id_s, bus.EX_RegSrc, bus.MEM_RegSrc);
    need_s    = (need_rs_s > need_rt_s) ? need_rs_s : need_rt_s;
  end

  // Next state and control outputs; dmem_busy freezes everything and holds the FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_write_s = 1'b1;
    memwb_write_s = 1'b1;
    stalling_s    = 1'b0;
    if (rst) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (bus.dmem_busy) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      exmem_write_s = 1'b0;
      memwb_write_s = 1'b0;
      stalling_s    = (state_q == STALL);
    end else if (state_q == STALL) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      idex_flush_s = 1'b1;
      stalling_s   = 1'b1;
      cnt_d        = cnt_q - STALL_W'(1);
      if (cnt_q == STALL_W'(1)) state_d = RUN;
      else                      state_d = STALL;
    end else if (need_s != 2'd0) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      idex_flush_s = 1'b1;
      stalling_s   = 1'b1;
      if (need_s == 2'd2) begin
        state_d = STALL;
        cnt_d   = STALL_W'(1);
      end else begin
        state_d = RUN;
      end
    end else begin
      ifid_flush_s = bus.ID_redirect;
    end
  end

  // FSM state and stall counter.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign bus.PC_Write    = pc_write_s;
  assign bus.IFID_Write  = ifid_write_s;
  assign bus.IFID_Flush  = ifid_flush_s;
  assign bus.IDEX_Flush  = idex_flush_s;
  assign bus.EXMEM_Write = exmem_write_s;
  assign bus.MEMWB_Write = memwb_write_s;
  assign bus.Stalling    = stalling_s;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  // Counters wrap naturally at 2^PERF_W.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (rst) begin
      perf_stall_d = '0;
      perf_flush_d = '0;
    end else begin
      if (stalling_s && !bus.dmem_busy) perf_stall_d = perf_stall_q + PERF_W'(1);
      else                              perf_stall_d = perf_stall_q;
      if (ifid_flush_s) perf_flush_d = perf_flush_q + PERF_W'(1);
      else              perf_flush_d = perf_flush_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    perf_stall_q <= perf_stall_d;
    perf_flush_q <= perf_flush_d;
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flushes      = perf_flush_q;
`else
  assign bus.perf_stall_cycles = {PERF_W{1'b0}};
  assign bus.perf_flushes      = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: load/ALU/PC+4 hazards, redirect, dmem freeze, reset.
module tb_hazard_ctrl;
  localparam logic [1:0] BR_NONE = 2'b00, BR_BEQ = 2'b01, J_NONE = 2'b00, J_REG = 2'b10;
  localparam logic [1:0] SRC_ALU = 2'b00, SRC_MEM = 2'b01, SRC_PC4 = 2'b10;
  // Packed {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Write, Stalling}
  localparam logic [6:0] O_RUN   = 7'b1100110;
  localparam logic [6:0] O_STALL = 7'b0001111;
  localparam logic [6:0] O_REDIR = 7'b1110110;
  localparam logic [6:0] O_BUSY  = 7'b0000000;
  localparam logic [6:0] O_BUSYS = 7'b0000001;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if #(.PERF_W(32)) bus ();
  hazard_ctrl #(.STALL_W(2), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus.PC_Write, bus.IFID_Write, bus.IFID_Flush, bus.IDEX_Flush,
            bus.EXMEM_Write, bus.MEMWB_Write, bus.Stalling};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.ID_rs = 5'd0;  bus.ID_rt = 5'd0;  bus.ID_useRs = 1'b0; bus.ID_useRt = 1'b0;
    bus.ID_Branch = BR_NONE; bus.ID_Jump = J_NONE; bus.ID_redirect = 1'b0;
    bus.EX_RegWrite = 1'b0;  bus.EX_RegSrc = SRC_ALU;  bus.EX_WriteReg = 5'd0;
    bus.MEM_RegWrite = 1'b0; bus.MEM_RegSrc = SRC_ALU; bus.MEM_WriteReg = 5'd0;
    bus.dmem_busy = 1'b0;
  endtask

  task automatic ex_prod(input logic [1:0] src, input logic [4:0] rd);
    bus.EX_RegWrite = 1'b1; bus.EX_RegSrc = src; bus.EX_WriteReg = rd;
  endtask

  task automatic mem_prod(input logic [1:0] src, input logic [4:0] rd);
    bus.MEM_RegWrite = 1'b1; bus.MEM_RegSrc = src; bus.MEM_WriteReg = rd;
  endtask

  task automatic id_rs(input logic [4:0] r, input logic [1:0] br, input logic [1:0] jmp);
    bus.ID_rs = r; bus.ID_useRs = 1'b1; bus.ID_Branch = br; bus.ID_Jump = jmp;
  endtask

  task automatic do_reset();
    clr(); rst = 1'b1; #2;
    chk("reset_outs", 32'(outs()), 32'(O_RUN));
    tick(); tick();
    chk("reset_perf_stall", bus.perf_stall_cycles, 32'd0);
    chk("reset_perf_flush", bus.perf_flushes, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    clr(); rst = 1'b1;
    tick();
    do_reset();

    // Redirect with no hazard: one-cycle IFID flush
    clr(); id_rs(5'd4, BR_BEQ, J_NONE); bus.ID_redirect = 1'b1; #2;
    chk("redirect_outs", 32'(outs()), 32'(O_REDIR));
    tick(); clr(); #2;
    chk("redirect_after", 32'(outs()), 32'(O_RUN));
    chk("redirect_perf", bus.perf_flushes, PERF ? 32'd1 : 32'd0);

    // lw in EX, beq on rs: two stall cycles, then run
    clr(); ex_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_BEQ, J_NONE); #2;
    chk("ldbr_c1", 32'(outs()), 32'(O_STALL));
    tick(); clr(); mem_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_BEQ, J_NONE); #2;
    chk("ldbr_c2", 32'(outs()), 32'(O_STALL));
    tick(); clr(); id_rs(5'd8, BR_BEQ, J_NONE); #2;
    chk("ldbr_c3", 32'(outs()), 32'(O_RUN));

    // lw in EX, add on rs: one stall cycle
    tick(); clr(); ex_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_NONE, J_NONE); #2;
    chk("ldadd_c1", 32'(outs()), 32'(O_STALL));
    tick(); clr(); mem_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_NONE, J_NONE); #2;
    chk("ldadd_c2", 32'(outs()), 32'(O_RUN));

    // addu in EX, jr on rs: one stall cycle
    tick(); clr(); ex_prod(SRC_ALU, 5'd9); id_rs(5'd9, BR_NONE, J_REG); #2;
    chk("alujr_c1", 32'(outs()), 32'(O_STALL));
    tick(); clr(); mem_prod(SRC_ALU, 5'd9); id_rs(5'd9, BR_NONE, J_REG); #2;
    chk("alujr_c2", 32'(outs()), 32'(O_RUN));

    // jal in EX, jr $ra: PC+4 is bypassable
    tick(); clr(); ex_prod(SRC_PC4, 5'd31); id_rs(5'd31, BR_NONE, J_REG); #2;
    chk("jaljr", 32'(outs()), 32'(O_RUN));

    // Load to $0 never stalls
    tick(); clr(); ex_prod(SRC_MEM, 5'd0); id_rs(5'd0, BR_BEQ, J_NONE); #2;
    chk("ld_r0", 32'(outs()), 32'(O_RUN));

    // rt path: unused rt does not stall, used rt does
    tick(); clr(); ex_prod(SRC_ALU, 5'd10); bus.ID_rt = 5'd10; bus.ID_Branch = BR_BEQ; #2;
    chk("rt_unused", 32'(outs()), 32'(O_RUN));
    bus.ID_useRt = 1'b1; #1;
    chk("rt_used", 32'(outs()), 32'(O_STALL));

    // Redirect is ignored while stalling
    tick(); clr(); ex_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_BEQ, J_NONE); bus.ID_redirect = 1'b1; #2;
    chk("redir_stall_c1", 32'(outs()), 32'(O_STALL));
    tick(); clr(); mem_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_BEQ, J_NONE); bus.ID_redirect = 1'b1; #2;
    chk("redir_stall_c2", 32'(outs()), 32'(O_STALL));
    tick(); clr(); id_rs(5'd8, BR_BEQ, J_NONE); bus.ID_redirect = 1'b1; #2;
    chk("redir_stall_c3", 32'(outs()), 32'(O_REDIR));

    // dmem_busy in RUN suppresses detection and redirect
    tick(); clr(); ex_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_BEQ, J_NONE);
    bus.ID_redirect = 1'b1; bus.dmem_busy = 1'b1; #2;
    chk("busy_run", 32'(outs()), 32'(O_BUSY));
    tick(); #2;
    chk("busy_run_hold", 32'(outs()), 32'(O_BUSY));

    // Load-branch stall with dmem_busy for 3 cycles in the middle
    tick(); do_reset();
    clr(); ex_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_BEQ, J_NONE); #2;
    chk("busy_ldbr_c1", 32'(outs()), 32'(O_STALL));
    tick(); clr(); mem_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_BEQ, J_NONE); bus.dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("busy_ldbr_hold", 32'(outs()), 32'(O_BUSYS));
      tick();
    end
    bus.dmem_busy = 1'b0; #2;
    chk("busy_ldbr_resume", 32'(outs()), 32'(O_STALL));
    tick(); clr(); id_rs(5'd8, BR_BEQ, J_NONE); #2;
    chk("busy_ldbr_done", 32'(outs()), 32'(O_RUN));
    chk("busy_ldbr_perf", bus.perf_stall_cycles, PERF ? 32'd2 : 32'd0);

    // Reset in STALL aborts the stall
    tick(); clr(); ex_prod(SRC_MEM, 5'd8); id_rs(5'd8, BR_BEQ, J_NONE); #2;
    chk("rst_stall_c1", 32'(outs()), 32'(O_STALL));
    tick(); clr(); rst = 1'b1; #2;
    chk("rst_stall_during", 32'(outs()), 32'(O_RUN));
    tick(); rst = 1'b0; #2;
    chk("rst_stall_after", 32'(outs()), 32'(O_RUN));
    chk("rst_stall_perf_s", bus.perf_stall_cycles, 32'd0);
    chk("rst_stall_perf_f", bus.perf_flushes, 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
